// File: rtl/strat_pkg.sv
// Shared types and defaults for the strategy scoring core.
package strat_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MAC    = 2'd1,
        S_DECIDE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam int DEF_W     = 32;
    localparam int DEF_WGT_W = 16;
    localparam int DEF_FRAC  = 8;
    localparam int DEF_ACC_W = 56;

    localparam logic HEAD_BUY  = 1'b0;
    localparam logic HEAD_SELL = 1'b1;

    // Smallest accumulator that cannot overflow summing feat_dim full products.
    function automatic int acc_w_min(input int w, input int wgt_w, input int feat_dim);
        return w + wgt_w + $clog2(feat_dim) + 1;
    endfunction

endpackage

// File: rtl/strat_mac_lane.sv
// One scoring head: FEAT_DIM-entry weight file plus a serial multiply-accumulate.
module strat_mac_lane #(
    parameter int W        = 32,
    parameter int WGT_W    = 16,
    parameter int FEAT_DIM = 4,
    parameter int ACC_W    = 56,
    parameter int IDX_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en_i,
    input  logic [IDX_W-1:0]        wr_idx_i,
    input  logic signed [WGT_W-1:0] wr_data_i,
    input  logic                    clr_i,
    input  logic                    mac_en_i,
    input  logic [IDX_W-1:0]        idx_i,
    input  logic signed [W-1:0]     feat_i,
    output logic signed [ACC_W-1:0] acc_o
);
    localparam int PROD_W = W + WGT_W;

    logic signed [WGT_W-1:0]  wgt_q [FEAT_DIM];
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_d;

    assign prod  = feat_i * wgt_q[idx_i];
    assign acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FEAT_DIM; i++) wgt_q[i] <= '0;
            acc_q <= '0;
        end else begin
            if (wr_en_i) wgt_q[wr_idx_i] <= wr_data_i;
            if (clr_i)
                acc_q <= '0;
            else if (mac_en_i)
                acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/strat_score_seq.sv
// BUY/SELL scoring core: serial dot product per head, ReLU, threshold, tie-break.
// Optional per-side cooldown enabled by defining STRAT_COOLDOWN_EN.
module strat_score_seq
    import strat_pkg::*;
#(
    parameter int W            = DEF_W,
    parameter int FEAT_DIM     = 4,
    parameter int WGT_W        = DEF_WGT_W,
    parameter int FRAC         = DEF_FRAC,
    parameter int ACC_W        = DEF_ACC_W,
    parameter int COOLDOWN_CYC = 16,
    localparam int IDX_W       = (FEAT_DIM > 1) ? $clog2(FEAT_DIM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FEAT_DIM*W-1:0] feat,
    input  logic                  wr_en,
    output logic                  wr_ready,
    input  logic                  wr_head,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [WGT_W-1:0]      wr_data,
    input  logic [ACC_W-1:0]      buy_thresh,
    input  logic [ACC_W-1:0]      sell_thresh,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  buy,
    output logic                  sell,
    output logic [ACC_W-1:0]      buy_score,
    output logic [ACC_W-1:0]      sell_score
);
    if (ACC_W < acc_w_min(W, WGT_W, FEAT_DIM)) begin : g_acc_w_chk
        $error("strat_score_seq: ACC_W too narrow for W, WGT_W and FEAT_DIM");
    end
    if (FRAC >= WGT_W || COOLDOWN_CYC < 1) begin : g_param_chk
        $error("strat_score_seq: FRAC must be below WGT_W and COOLDOWN_CYC positive");
    end

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic signed [W-1:0]     feat_q [FEAT_DIM];
    logic                    out_valid_q, buy_q, sell_q;
    logic [ACC_W-1:0]        buy_score_q, sell_score_q;
    logic signed [ACC_W-1:0] acc_b, acc_s;
    logic [ACC_W-1:0]        relu_b_d, relu_s_d;
    logic                    idle, start, bq_d, sq_d, buy_d, sell_d;
    logic                    wr_b, wr_s, accept_buy, accept_sell;

    assign idle     = (state_q == S_IDLE);
    assign start    = idle & in_valid;
    assign wr_b     = idle & wr_en & (wr_head == HEAD_BUY);
    assign wr_s     = idle & wr_en & (wr_head == HEAD_SELL);
    assign in_ready = idle;
    assign wr_ready = idle;

    strat_mac_lane #(.W(W), .WGT_W(WGT_W), .FEAT_DIM(FEAT_DIM), .ACC_W(ACC_W), .IDX_W(IDX_W)) u_lane_buy (
        .clk(clk), .rst(rst), .wr_en_i(wr_b), .wr_idx_i(wr_idx), .wr_data_i(wr_data),
        .clr_i(start), .mac_en_i(state_q == S_MAC), .idx_i(idx_q), .feat_i(feat_q[idx_q]),
        .acc_o(acc_b)
    );
    strat_mac_lane #(.W(W), .WGT_W(WGT_W), .FEAT_DIM(FEAT_DIM), .ACC_W(ACC_W), .IDX_W(IDX_W)) u_lane_sell (
        .clk(clk), .rst(rst), .wr_en_i(wr_s), .wr_idx_i(wr_idx), .wr_data_i(wr_data),
        .clr_i(start), .mac_en_i(state_q == S_MAC), .idx_i(idx_q), .feat_i(feat_q[idx_q]),
        .acc_o(acc_s)
    );

    assign accept_buy  = (state_q == S_HOLD) & out_ready & buy_q;
    assign accept_sell = (state_q == S_HOLD) & out_ready & sell_q;

    assign relu_b_d = acc_b[ACC_W-1] ? '0 : acc_b;
    assign relu_s_d = acc_s[ACC_W-1] ? '0 : acc_s;

`ifdef STRAT_COOLDOWN_EN
    localparam int CD_W = $clog2(COOLDOWN_CYC + 1);
    logic [CD_W-1:0] cd_b_q, cd_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cd_b_q <= '0;
            cd_s_q <= '0;
        end else begin
            if (accept_buy)          cd_b_q <= CD_W'(COOLDOWN_CYC);
            else if (cd_b_q != '0)   cd_b_q <= cd_b_q - 1'b1;
            if (accept_sell)         cd_s_q <= CD_W'(COOLDOWN_CYC);
            else if (cd_s_q != '0)   cd_s_q <= cd_s_q - 1'b1;
        end
    end

    assign bq_d = ($signed(relu_b_d) > $signed(buy_thresh))  & (cd_b_q == '0);
    assign sq_d = ($signed(relu_s_d) > $signed(sell_thresh)) & (cd_s_q == '0);
`else
    logic unused_accept;
    assign unused_accept = accept_buy ^ accept_sell;
    assign bq_d = $signed(relu_b_d) > $signed(buy_thresh);
    assign sq_d = $signed(relu_s_d) > $signed(sell_thresh);
`endif

    // Scores are non-negative after ReLU, so an unsigned compare resolves the tie-break.
    assign buy_d  = bq_d & (~sq_d | (relu_b_d > relu_s_d));
    assign sell_d = sq_d & (~bq_d | (relu_s_d > relu_b_d));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            out_valid_q  <= 1'b0;
            buy_q        <= 1'b0;
            sell_q       <= 1'b0;
            buy_score_q  <= '0;
            sell_score_q <= '0;
            for (int i = 0; i < FEAT_DIM; i++) feat_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    for (int i = 0; i < FEAT_DIM; i++) feat_q[i] <= feat[i*W +: W];
                    idx_q   <= '0;
                    state_q <= S_MAC;
                end
                S_MAC: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDX_W'(FEAT_DIM - 1)) state_q <= S_DECIDE;
                end
                S_DECIDE: begin
                    buy_score_q  <= relu_b_d;
                    sell_score_q <= relu_s_d;
                    buy_q        <= buy_d;
                    sell_q       <= sell_d;
                    out_valid_q  <= 1'b1;
                    state_q      <= S_HOLD;
                end
                S_HOLD: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    buy_q       <= 1'b0;
                    sell_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign buy        = buy_q;
    assign sell       = sell_q;
    assign buy_score  = buy_score_q;
    assign sell_score = sell_score_q;

endmodule

// File: tb/tb_strat_score_seq.sv
// Directed self-checking bench for strat_score_seq with hand-computed expectations.
module tb_strat_score_seq;
    localparam int W = 32, FEAT_DIM = 4, WGT_W = 16, FRAC = 8, ACC_W = 56, CD = 16;
    localparam int IDX_W = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0, in_ready;
    logic [FEAT_DIM*W-1:0] feat = '0;
    logic                  wr_en = 1'b0, wr_ready, wr_head = 1'b0;
    logic [IDX_W-1:0]      wr_idx = '0;
    logic [WGT_W-1:0]      wr_data = '0;
    logic [ACC_W-1:0]      buy_thresh = '0, sell_thresh = '0;
    logic                  out_valid, out_ready = 1'b0, buy, sell;
    logic [ACC_W-1:0]      buy_score, sell_score;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    strat_score_seq #(.W(W), .FEAT_DIM(FEAT_DIM), .WGT_W(WGT_W), .FRAC(FRAC),
                      .ACC_W(ACC_W), .COOLDOWN_CYC(CD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .feat(feat),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_head(wr_head), .wr_idx(wr_idx),
        .wr_data(wr_data), .buy_thresh(buy_thresh), .sell_thresh(sell_thresh),
        .out_valid(out_valid), .out_ready(out_ready), .buy(buy), .sell(sell),
        .buy_score(buy_score), .sell_score(sell_score)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_feat(input int f0, input int f1, input int f2, input int f3);
        feat = {f3, f2, f1, f0};
    endtask

    task automatic write_w(input logic head, input int idx, input int data);
        wr_en = 1'b1; wr_head = head; wr_idx = IDX_W'(idx); wr_data = WGT_W'(data);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        chk("busy_in_ready", longint'(in_ready), 0);
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", n, FEAT_DIM + 1);
    endtask

    task automatic run_vec(input int f0, input int f1, input int f2, input int f3);
        set_feat(f0, f1, f2, f3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out();
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("accept_out_valid", longint'(out_valid), 0);
        chk("accept_in_ready", longint'(in_ready), 1);
    endtask

    task automatic chk_out(input string tag, input longint bs, input longint ss,
                           input logic eb, input logic es);
        chk({tag, "_buy_score"}, longint'(buy_score), bs);
        chk({tag, "_sell_score"}, longint'(sell_score), ss);
        chk({tag, "_buy"}, longint'(buy), longint'(eb));
        chk({tag, "_sell"}, longint'(sell), longint'(es));
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_out_valid", longint'(out_valid), 0);
        chk_out("rst", 0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_wr_ready", longint'(wr_ready), 1);

        // BUY head only: -3840 + 51200 = 47360
        write_w(1'b0, 0, -384);
        write_w(1'b0, 1, 512);
        write_w(1'b0, 2, -128);
        write_w(1'b0, 3, -25);
        buy_thresh = ACC_W'(25600);
        sell_thresh = '0;
        run_vec(10, 100, 0, 0);
        chk_out("v1", 47360, 0, 1'b1, 1'b0);
        accept();
        chk("v1_score_hold", longint'(buy_score), 47360);

        // Strict compare at exact threshold
        buy_thresh = ACC_W'(47360);
        run_vec(10, 100, 0, 0);
        chk("v2_out_valid", longint'(out_valid), 1);
        chk_out("v2", 47360, 0, 1'b0, 1'b0);
        accept();

        // Negative accumulator clamps to 0; 0 > -1 fires with a signed threshold
        buy_thresh = '1;
        run_vec(10, 0, 0, 0);
        chk_out("relu", 0, 0, 1'b1, 1'b0);
        accept();

        // Equal weights on both heads: tie, neither fires
        for (int i = 0; i < FEAT_DIM; i++) begin
            write_w(1'b0, i, 256);
            write_w(1'b1, i, 256);
        end
        buy_thresh = '0;
        sell_thresh = '0;
        run_vec(1, 1, 1, 1);
        chk_out("tie", 1024, 1024, 1'b0, 1'b0);
        accept();

        // Write and accept in the same IDLE cycle: new SELL weight 512 is used
        wr_en = 1'b1; wr_head = 1'b1; wr_idx = '0; wr_data = WGT_W'(512);
        set_feat(1, 1, 1, 1);
        in_valid = 1'b1;
        tick();
        wr_en = 1'b0; in_valid = 1'b0;
        wait_out();
        chk_out("wr_same", 1024, 1280, 1'b0, 1'b1);

        // Backpressure: outputs stable, new vector and weight write ignored
        set_feat(5, 5, 5, 5);
        in_valid = 1'b1;
        wr_en = 1'b1; wr_head = 1'b0; wr_idx = '0; wr_data = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_out_valid", longint'(out_valid), 1);
            chk("hold_in_ready", longint'(in_ready), 0);
            chk("hold_wr_ready", longint'(wr_ready), 0);
            chk_out("hold", 1024, 1280, 1'b0, 1'b1);
        end
        in_valid = 1'b0;
        wr_en = 1'b0;
        accept();
        run_vec(1, 1, 1, 1);
        chk_out("post_hold", 1024, 1280, 1'b0, 1'b1);
        accept();

        // Reset in the middle of MAC (idx=2)
        set_feat(1, 1, 1, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_in_ready", longint'(in_ready), 1);
        chk_out("midrst", 0, 0, 1'b0, 1'b0);
        run_vec(1, 1, 1, 1);
        chk_out("midrst_rb", 0, 0, 1'b0, 1'b0);
        accept();

`ifdef STRAT_COOLDOWN_EN
        // Buy accepted, then resend: suppressed until DECIDE falls 17+ edges after acceptance
        begin
            int acc_edge;
            write_w(1'b0, 0, 256);
            buy_thresh = '0;
            run_vec(100, 0, 0, 0);
            chk_out("cd_first", 25600, 0, 1'b1, 1'b0);
            accept();
            acc_edge = cyc;
            for (int k = 0; k < 3; k++) begin
                int dec_edge;
                run_vec(100, 0, 0, 0);
                dec_edge = cyc;
                chk("cd_buy", longint'(buy), longint'((dec_edge - acc_edge) >= CD + 1));
                chk("cd_score", longint'(buy_score), 25600);
                accept();
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
